// File: rtl/pp_accum_multiplier.sv
// Purpose : sequential unsigned shift-add multiplier, one AND partial-product row accumulated per RUN cycle.
// Latency : out_valid appears WIDTH edges after the accept edge; one operation per WIDTH+2 cycles with out_ready held high.
// Backpressure: product and out_valid hold in DONE until out_ready; in_ready stays low until the cycle after the handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset; aborts any operation in flight
//   in_valid   operands a/b valid          in_ready   high only in IDLE
//   a, b       unsigned WIDTH-bit operands captured at accept
//   out_valid  high only in DONE           out_ready  consumer takes product
//   product    registered 2*WIDTH-bit a*b, held until next completion or reset
//   busy       high in RUN or DONE

module pp_accum_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   localparam int PW = 2 * WIDTH;
   // One extra bit so the counter can step past WIDTH-1 without wrapping.
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic [WIDTH-1:0]  mcand;
   logic [WIDTH-1:0]  mplier;
   logic [PW-1:0]     acc;
   logic [PW-1:0]     product_q;
   logic [CW-1:0]     cnt;

   logic              accept;
   logic              run_step;
   logic              last_step;
   logic [WIDTH-1:0]  pp_row;
   logic [PW-1:0]     pp_shifted;
   logic [PW-1:0]     acc_sum;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and handshake outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      accept    = 1'b0;
      run_step  = 1'b0;
      last_step = 1'b0;

      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end

         RUN: begin
            busy     = 1'b1;
            run_step = 1'b1;
            // No early-out: all WIDTH multiplier bits are processed even when zero.
            if (cnt == LAST_CNT) begin
               last_step = 1'b1;
               state_nxt = DONE;
            end
         end

         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            // Return to IDLE only; the next accept happens one cycle later.
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Partial-product row: mplier is shifted right each step, so bit 0
   // always holds the multiplier bit that matches the current cnt.
   // ------------------------------------------------------------------
   always_comb begin
      pp_row     = mcand & {WIDTH{mplier[0]}};
      pp_shifted = {{WIDTH{1'b0}}, pp_row} << cnt;
      acc_sum    = acc + pp_shifted;
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         cnt       <= '0;
         product_q <= '0;
      end else begin
         if (accept) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
         end
         if (run_step) begin
            acc    <= acc_sum;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
         end
         // The final row is folded in on the same edge the result is published.
         if (last_step) begin
            product_q <= acc_sum;
         end
      end
   end

   assign product = product_q;

   // ------------------------------------------------------------------
   // Protocol properties
   // ------------------------------------------------------------------
   property p_hold_under_backpressure;
      @(posedge clk) disable iff (!rst_n)
         (out_valid && !out_ready) |=> (out_valid && $stable(product));
   endproperty
   a_hold_under_backpressure : assert property (p_hold_under_backpressure);

   property p_ready_valid_exclusive;
      @(posedge clk) disable iff (!rst_n)
         !(in_ready && out_valid);
   endproperty
   a_ready_valid_exclusive : assert property (p_ready_valid_exclusive);

endmodule

// File: tb/tb_pp_accum_multiplier.sv
// Purpose : self-checking bench for pp_accum_multiplier (WIDTH=8).
// Latency : directed vectors expect out_valid exactly 8 edges after accept.
// Backpressure: exercised with held out_ready=0 and random out_ready toggling.

module tb_pp_accum_multiplier;

   localparam int WIDTH = 8;
   localparam int NRAND = 1000;
   localparam int NCONST = 30;
   localparam int NTOT = NRAND + NCONST;

   logic                clk;
   logic                rst_n;
   logic                in_valid;
   logic                in_ready;
   logic [WIDTH-1:0]    a;
   logic [WIDTH-1:0]    b;
   logic                out_valid;
   logic                out_ready;
   logic [2*WIDTH-1:0]  product;
   logic                busy;

   int total;
   int bad;

   pp_accum_multiplier #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0]   a;
      logic [WIDTH-1:0]   b;
      logic [2*WIDTH-1:0] exp_p;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full operation with out_ready held high; operands are scrambled
   // right after accept to show they were captured.
   task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic [2*WIDTH-1:0] exp_p, input string name);
      int lat;
      check({name, "_in_ready_pre"}, 32'(in_ready), 32'd1);
      a         = av;
      b         = bv;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      check({name, "_busy_run"}, 32'(busy), 32'd1);
      lat = 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      check({name, "_latency"}, 32'(lat), 32'(WIDTH));
      check({name, "_product"}, 32'(product), 32'(exp_p));
      tick();
      check({name, "_in_ready_post"}, 32'(in_ready), 32'd1);
      check({name, "_out_valid_post"}, 32'(out_valid), 32'd0);
      check({name, "_product_kept"}, 32'(product), 32'(exp_p));
   endtask

   initial begin
      int n_acc;
      int n_done;
      int last_acc;
      bit prev_ov;
      bit acc_hs;
      bit out_hs;
      int acc_cyc_q[$];
      int exp_q[$];

      total = 0;
      bad   = 0;

      vecs[0] = '{a: 8'd3,   b: 8'd5,    exp_p: 16'h000F};
      vecs[1] = '{a: 8'd255, b: 8'd255,  exp_p: 16'hFE01};
      vecs[2] = '{a: 8'd0,   b: 8'hA7,   exp_p: 16'h0000};
      vecs[3] = '{a: 8'h80,  b: 8'h80,   exp_p: 16'h4000};
      vecs[4] = '{a: 8'd1,   b: 8'd255,  exp_p: 16'h00FF};

      // Reset state
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      tick();
      tick();
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_product",   32'(product),   32'd0);
      rst_n = 1'b1;
      tick();

      // Directed table
      for (int i = 0; i < 5; i++) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].exp_p, $sformatf("vec%0d", i));
      end

      // Backpressure: result held, in_ready low, stray in_valid ignored
      a         = 8'd12;
      b         = 8'd11;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 40 && !out_valid; k++) tick();
      check("bp_first_valid", 32'(out_valid), 32'd1);
      for (int k = 0; k < 5; k++) begin
         a        = 8'd1;
         b        = 8'd1;
         in_valid = 1'b1;
         tick();
         check("bp_product",   32'(product),   32'h0084);
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_in_ready",  32'(in_ready),  32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check("bp_release_in_ready", 32'(in_ready), 32'd1);
      check("bp_release_busy",     32'(busy),     32'd0);
      do_op(8'd13, 8'd17, 16'd221, "bp_next");

      // Reset on the 4th RUN edge
      a        = 8'd200;
      b        = 8'd100;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      check("midrst_in_ready",  32'(in_ready),  32'd1);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_busy",      32'(busy),      32'd0);
      check("midrst_product",   32'(product),   32'd0);
      rst_n = 1'b1;
      tick();
      do_op(8'd7, 8'd9, 16'h003F, "after_rst");

      // Random back-to-back against the a*b model
      n_acc    = 0;
      n_done   = 0;
      last_acc = 0;
      prev_ov  = 1'b0;
      a        = WIDTH'($urandom);
      b        = WIDTH'($urandom);
      in_valid = 1'b1;
      out_ready = 1'($urandom_range(0, 1));
      for (int cyc = 0; cyc < 60000 && n_done < NTOT; cyc++) begin
         @(negedge clk);
         acc_hs = in_ready && in_valid;
         out_hs = out_valid && out_ready;
         if (out_valid && !prev_ov) begin
            if (acc_cyc_q.size() > 0)
               check("rand_latency", 32'(cyc - acc_cyc_q.pop_front()), 32'(WIDTH));
            else
               check("rand_unexpected_valid", 32'd1, 32'd0);
         end
         prev_ov = out_valid;
         if (out_hs) begin
            if (exp_q.size() > 0)
               check("rand_product", 32'(product), 32'(exp_q.pop_front()));
            else
               check("rand_unexpected_result", 32'd1, 32'd0);
            n_done++;
         end
         if (acc_hs) begin
            exp_q.push_back(int'(a) * int'(b));
            // First cycle after the accept edge; out_valid is due WIDTH cycles later.
            acc_cyc_q.push_back(cyc + 1);
            if (n_acc >= NRAND + 1)
               check("const_spacing", 32'(cyc - last_acc), 32'(WIDTH + 2));
            last_acc = cyc;
            n_acc++;
         end
         @(posedge clk);
         #1;
         if (acc_hs) begin
            if (n_acc < NTOT) begin
               a = WIDTH'($urandom);
               b = WIDTH'($urandom);
            end else begin
               in_valid = 1'b0;
            end
         end
         out_ready = (n_acc >= NRAND) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      check("rand_all_done",  32'(n_done), 32'(NTOT));
      check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
